conv1_ofm_writer: RTL and testbench



---
 rtl/conv1_ofm_writer.sv | 124 ++++++++++++
 tb/tb_conv1_ofm_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_ofm_writer.sv
// conv1 output feature-map writer: buffers conv1 pixel vectors and
// serialises each one into LANES-wide words for the ofm RAM.
module conv1_ofm_writer #(
    parameter int WOUT   = 128,
    parameter int CHOUT  = 64,
    parameter int WIDTH  = 16,
    parameter int LANES  = 8,
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   conv1_sample,
    input  logic [WIDTH-1:0]       ofm [0:CHOUT-1],
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [WIDTH*LANES-1:0] ram_wdata,
    output logic                   ram_feedback,
    output logic                   writer_busy,
    output logic                   overflow
);
    localparam int GROUPS    = CHOUT / LANES;
    localparam int PIX_TOTAL = WOUT * WOUT;
    localparam int GW        = $clog2(GROUPS);
    localparam int PIX_W     = ADDR_W - GW + 1;
    localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW        = $clog2(DEPTH + 1);
    localparam int CIW       = $clog2(CHOUT);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t             state, state_n;
    logic [GW-1:0]      g, g_n;
    logic [PIX_W-1:0]   pix, pix_n;
    logic [PW-1:0]      wptr, rptr;
    logic [CW-1:0]      count, count_n;
    logic               issue, last, pop, accept, push, drop;
    logic [WIDTH*LANES-1:0] word;
    logic [WIDTH-1:0]   vbuf [0:DEPTH-1][0:CHOUT-1];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        word = '0;
        for (int k = 0; k < LANES; k++)
            word[k*WIDTH +: WIDTH] = vbuf[rptr][CIW'(int'(g) * LANES + k)];
    end

    always_comb begin
        state_n = state;
        g_n     = g;
        pix_n   = pix;
        issue   = 1'b0;
        unique case (state)
            IDLE:    issue = (count != '0);
            WRITE:   issue = 1'b1;
            DONE:    issue = 1'b0;
            default: state_n = IDLE;
        endcase
        last    = issue && (g == GW'(GROUPS - 1));
        pop     = last;
        accept  = conv1_sample && (state != DONE);
        push    = accept && ((count != CW'(DEPTH)) || pop);
        drop    = accept && !push;
        count_n = count + CW'(push) - CW'(pop);
        if (issue) begin
            state_n = WRITE;
            g_n     = g + GW'(1);
            if (last) begin
                // a vector waiting (or arriving now) keeps the stream gapless
                g_n   = '0;
                pix_n = pix + PIX_W'(1);
                if (pix_n == PIX_W'(PIX_TOTAL))
                    state_n = DONE;
                else if (count_n == '0)
                    state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            g            <= '0;
            pix          <= '0;
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_feedback <= 1'b0;
            writer_busy  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state  <= state_n;
            g      <= g_n;
            pix    <= pix_n;
            count  <= count_n;
            ram_we <= issue;
            if (push)
                wptr <= ptr_inc(wptr);
            if (pop)
                rptr <= ptr_inc(rptr);
            if (issue) begin
                ram_addr  <= {pix[PIX_W-2:0], g};
                ram_wdata <= word;
            end
            if (state == DONE)
                ram_feedback <= 1'b1;
            if (drop)
                overflow <= 1'b1;
            writer_busy <= (count_n != '0) || issue || (state_n == WRITE);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            for (int i = 0; i < CHOUT; i++)
                vbuf[wptr][i] <= ofm[i];
    end
endmodule

// File: tb/tb_conv1_ofm_writer.sv
// Bench for conv1_ofm_writer: directed timing plus random pixel vectors
// scored against an arithmetic model of the expected RAM write stream.
`timescale 1ns/1ps
module tb_conv1_ofm_writer;
    localparam int CH = 64;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [16:0]  addr;
        logic [127:0] data;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         smp_m = 1'b0, smp_s = 1'b0;
    logic [15:0]  ofm [0:CH-1];
    logic [15:0]  vec [0:CH-1];
    logic         we_m, we_s, fb_m, fb_s, busy_m, busy_s, ovf_m, ovf_s;
    logic [16:0]  addr_m;
    logic [8:0]   addr_s;
    logic [127:0] wd_m, wd_s;

    int  cyc = 0;
    int  checks = 0, fails = 0;
    wr_t obs_q [2][$];
    wr_t exp_q [2][$];
    int  m_lw [2], m_lwp [2], m_nacc [2];
    bit  m_ovf [2];
    int  ptot [2] = '{16384, 64};

    conv1_ofm_writer dut (
        .clk(clk), .rst(rst), .conv1_sample(smp_m), .ofm(ofm),
        .ram_we(we_m), .ram_addr(addr_m), .ram_wdata(wd_m),
        .ram_feedback(fb_m), .writer_busy(busy_m), .overflow(ovf_m)
    );

    conv1_ofm_writer #(.WOUT(8), .ADDR_W(9)) dsm (
        .clk(clk), .rst(rst), .conv1_sample(smp_s), .ofm(ofm),
        .ram_we(we_s), .ram_addr(addr_s), .ram_wdata(wd_s),
        .ram_feedback(fb_s), .writer_busy(busy_s), .overflow(ovf_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we_m) obs_q[0].push_back(wr_t'({32'(cyc), addr_m, wd_m}));
        if (we_s) obs_q[1].push_back(wr_t'({32'(cyc), 8'b0, addr_s, wd_s}));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [255:0] o, logic [255:0] e);
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic void model_reset(int m);
        m_lw[m]   = -100;
        m_lwp[m]  = -100;
        m_nacc[m] = 0;
        m_ovf[m]  = 1'b0;
        exp_q[m].delete();
    endfunction

    // Pixel n owns words n*8..n*8+7, written one per cycle once it is at the
    // head; a vector leaves the 2-deep buffer in the cycle its last word issues.
    function automatic void model_sample(int m, int t);
        int occ, fw;
        logic [127:0] w;
        if (m_nacc[m] >= ptot[m]) return;
        occ = int'(m_lw[m] - 1 > t) + int'(m_lwp[m] - 1 > t);
        if (occ >= 2) begin
            m_ovf[m] = 1'b1;
            return;
        end
        fw = (t + 2 > m_lw[m] + 1) ? t + 2 : m_lw[m] + 1;
        for (int g = 0; g < 8; g++) begin
            w = '0;
            for (int k = 0; k < 8; k++) w[k*16 +: 16] = vec[g*8+k];
            exp_q[m].push_back(wr_t'({32'(fw + g), 17'(m_nacc[m]*8 + g), w}));
        end
        m_lwp[m] = m_lw[m];
        m_lw[m]  = fw + 7;
        m_nacc[m]++;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            model_reset(m);
            obs_q[m].delete();
        end
    endtask

    task automatic randvec();
        for (int i = 0; i < CH; i++) vec[i] = 16'($urandom);
    endtask

    task automatic do_sample(int m);
        ofm = vec;
        if (m == 0) smp_m = 1'b1;
        else smp_s = 1'b1;
        model_sample(m, cyc);
        tick();
        smp_m = 1'b0;
        smp_s = 1'b0;
    endtask

    task automatic cmp_writes(int m, string tag);
        int last, n, ne, no;
        last = cyc;
        n = 0;
        if (exp_q[m].size() > 0)
            last = int'(exp_q[m][exp_q[m].size()-1].cyc);
        while (cyc <= last + 1 && n < 4000) begin
            tick();
            n++;
        end
        ne = exp_q[m].size();
        no = obs_q[m].size();
        chk({tag, "_count"}, 256'(no), 256'(ne));
        for (int i = 0; i < ne && i < no; i++)
            chk($sformatf("%s_wr%0d", tag, i), 256'(obs_q[m][i]), 256'(exp_q[m][i]));
        obs_q[m].delete();
        exp_q[m].delete();
    endtask

    initial begin
        int t0, t5, tl;
        logic [127:0] w;
        wr_t keep [$];
        for (int i = 0; i < CH; i++) begin
            ofm[i] = '0;
            vec[i] = '0;
        end

        do_reset();
        chk("rst_we", 256'(we_m), 256'(0));
        chk("rst_addr", 256'(addr_m), 256'(0));
        chk("rst_wdata", 256'(wd_m), 256'(0));
        chk("rst_flags", {fb_m, busy_m, ovf_m}, 256'(0));

        // single pixel, ofm[i] = i+1
        for (int i = 0; i < CH; i++) vec[i] = 16'(i + 1);
        t0 = cyc;
        do_sample(0);
        while (cyc < t0 + 2) tick();
        w = '0;
        for (int k = 0; k < 8; k++) w[k*16 +: 16] = 16'(k + 1);
        chk("s1_word0", {we_m, addr_m, wd_m}, {1'b1, 17'd0, w});
        while (cyc < t0 + 9) tick();
        for (int k = 0; k < 8; k++) w[k*16 +: 16] = 16'(k + 57);
        chk("s1_word7", {we_m, addr_m, wd_m}, {1'b1, 17'd7, w});
        chk("s1_busy_last", 256'(busy_m), 256'(1));
        tick();
        chk("s1_busy_fall", {busy_m, we_m}, 256'(0));
        cmp_writes(0, "s1");

        // three pixels at conv1's 28-cycle spacing
        do_reset();
        for (int p = 1; p <= 3; p++) begin
            for (int i = 0; i < CH; i++) vec[i] = 16'(p * 100 + i);
            do_sample(0);
            repeat (27) tick();
        end
        cmp_writes(0, "s2");
        chk("s2_ovf", 256'(ovf_m), 256'(m_ovf[0]));

        // three back-to-back samples: the third finds the buffer full
        do_reset();
        randvec();
        do_sample(0);
        randvec();
        do_sample(0);
        chk("s3_ovf_before", 256'(ovf_m), 256'(0));
        randvec();
        do_sample(0);
        chk("s3_ovf_after", 256'(ovf_m), 256'(m_ovf[0]));
        chk("s3_model_ovf", 256'(m_ovf[0]), 256'(ovf_m));
        cmp_writes(0, "s3");
        chk("s3_ovf_sticky", 256'(ovf_m), 256'(1));

        // push into a full buffer in the same cycle as the head pop
        do_reset();
        t0 = cyc;
        randvec();
        do_sample(0);
        randvec();
        do_sample(0);
        while (cyc < t0 + 8) tick();
        randvec();
        do_sample(0);
        cmp_writes(0, "s4");
        chk("s4_ovf", 256'(ovf_m), 256'(m_ovf[0]));

        // reset during g=3 of pixel 5 with one vector buffered
        do_reset();
        for (int p = 0; p < 5; p++) begin
            randvec();
            do_sample(0);
            repeat (27) tick();
        end
        t5 = cyc;
        randvec();
        do_sample(0);
        randvec();
        do_sample(0);
        while (cyc < t5 + 5) tick();
        chk("s5_g3", {we_m, addr_m}, {1'b1, 17'd43});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_after_rst", {we_m, busy_m}, 256'(0));
        keep.delete();
        for (int i = 0; i < exp_q[0].size(); i++)
            if (int'(exp_q[0][i].cyc) <= t5 + 5) keep.push_back(exp_q[0][i]);
        exp_q[0] = keep;
        cmp_writes(0, "s5pre");
        model_reset(0);
        randvec();
        do_sample(0);
        cmp_writes(0, "s5post");

        // complete map on an 8x8 instance
        do_reset();
        for (int p = 0; p < 63; p++) begin
            randvec();
            do_sample(1);
            repeat (27) tick();
        end
        tl = cyc;
        randvec();
        do_sample(1);
        while (cyc < tl + 9) tick();
        chk("s6_last_write", {we_s, addr_s, fb_s}, {1'b1, 9'd511, 1'b0});
        tick();
        chk("s6_feedback", {fb_s, we_s}, 256'(2));
        cmp_writes(1, "s6");
        randvec();
        do_sample(1);
        repeat (12) tick();
        chk("s6_done_flags", {fb_s, ovf_s, busy_s}, 256'(4));
        cmp_writes(1, "s6extra");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
